// File: rtl/wb_stream_loader.sv
// wb_stream_loader
//   Wishbone master that loads a byte stream into a Wishbone slave RAM.
//   Bytes are packed big-endian into 32-bit words (first byte -> [31:24]) and
//   written to consecutive word addresses starting at a latched base. A short
//   final word carries zeros and cleared byte selects in its unfilled lanes.
//   A bus cycle that waits TIMEOUT cycles without ack aborts the load and sets
//   the sticky error flag.
//
//   Optional feature macro: WB_STREAM_LOADER_VERIFY_EN
//     When defined, every acknowledged write is followed (after one idle
//     cycle) by a read of the same word. The selected bytes are compared with
//     the written data, and a mismatch aborts the load with err_o.
//
// Ports
//   wb_clk_i, wb_rst_n_i     clock, asynchronous active-low reset
//   start_i                  pulse: latch base_adr_i/len_i and begin (IDLE only)
//   base_adr_i, len_i        start byte address (bits [1:0] ignored), byte count
//   s_dat_i/s_valid_i/s_ready_o  byte stream in
//   wb_adr_o..wb_ack_i       Wishbone master (cyc == stb)
//   busy_o, done_o, err_o    status: load active, end pulse, sticky error
//
// State  | meaning
// IDLE   | waiting for start_i
// FILL   | accepting stream bytes into the word buffer
// WRITE  | write cycle in progress, waiting for ack
// VGAP   | idle cycle between write and read-back (verify build only)
// VERIFY | read-back cycle in progress (verify build only)
// DONE   | one-cycle end-of-load pulse
module wb_stream_loader #(
  parameter int AWIDTH  = 13,
  parameter int LWIDTH  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] base_adr_i,
  input  logic [LWIDTH-1:0] len_i,
  input  logic [7:0]        s_dat_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [AWIDTH-1:0] wb_adr_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AWIDTH-1:0] ADR_STEP = AWIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WRITE, S_VGAP, S_VERIFY, S_DONE
  } state_t;

  state_t            state_q;
  logic [AWIDTH-1:0] adr_q;
  logic [31:0]       dat_q;
  logic [3:0]        sel_q;
  logic [LWIDTH-1:0] rem_q;
  logic [1:0]        bidx_q;
  logic [TW-1:0]     tmr_q;
  logic              err_q;

`ifdef WB_STREAM_LOADER_VERIFY_EN
  logic [31:0] sel_mask;
  logic        verify_bad;
  assign sel_mask   = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
  assign verify_bad = |((wb_dat_i ^ dat_q) & sel_mask);
`else
  logic unused_rd_dat;
  assign unused_rd_dat = ^wb_dat_i;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
      bidx_q  <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_q   <= 1'b0;
            adr_q   <= {base_adr_i[AWIDTH-1:2], 2'b00};
            rem_q   <= len_i;
            dat_q   <= '0;
            sel_q   <= '0;
            bidx_q  <= '0;
            state_q <= (len_i == '0) ? S_DONE : S_FILL;
          end
        end

        S_FILL: begin
          if (s_valid_i) begin
            // ~bidx_q is the byte lane: byte 0 -> lane 3 (bits 31:24)
            dat_q[{~bidx_q, 3'b000} +: 8] <= s_dat_i;
            sel_q[~bidx_q]                <= 1'b1;
            bidx_q                        <= bidx_q + 2'd1;
            rem_q                         <= rem_q - LWIDTH'(1);
            if (bidx_q == 2'd3 || rem_q == LWIDTH'(1)) begin
              tmr_q   <= TW'(TIMEOUT - 1);
              state_q <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          if (wb_ack_i) begin
`ifdef WB_STREAM_LOADER_VERIFY_EN
            state_q <= S_VGAP;
`else
            adr_q   <= adr_q + ADR_STEP;
            dat_q   <= '0;
            sel_q   <= '0;
            bidx_q  <= '0;
            state_q <= (rem_q == '0) ? S_DONE : S_FILL;
`endif
          end else if (tmr_q == '0) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end

`ifdef WB_STREAM_LOADER_VERIFY_EN
        S_VGAP: begin
          tmr_q   <= TW'(TIMEOUT - 1);
          state_q <= S_VERIFY;
        end

        S_VERIFY: begin
          if (wb_ack_i) begin
            if (verify_bad) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              adr_q   <= adr_q + ADR_STEP;
              dat_q   <= '0;
              sel_q   <= '0;
              bidx_q  <= '0;
              state_q <= (rem_q == '0) ? S_DONE : S_FILL;
            end
          end else if (tmr_q == '0) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
`endif

        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so an async reset drops
  // stb/cyc/busy in the same cycle.
  assign s_ready_o = (state_q == S_FILL);
  assign wb_stb_o  = (state_q == S_WRITE) || (state_q == S_VERIFY);
  assign wb_cyc_o  = wb_stb_o;
  assign wb_we_o   = (state_q == S_WRITE);
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign busy_o    = (state_q == S_FILL) || (state_q == S_WRITE) ||
                     (state_q == S_VGAP) || (state_q == S_VERIFY);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_wb_stream_loader.sv
module tb_wb_stream_loader;

  localparam int AW = 13;
  localparam int LW = 16;
  localparam int TO = 255;
  localparam int NWORDS = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_adr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic [7:0]    s_dat_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [31:0]   rdat;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_stb_o, wb_cyc_o;
  logic          ack;
  logic          busy_o, done_o, err_o;

  int n_chk = 0;
  int n_fail = 0;

  bit ack_en = 1'b1;
  bit corrupt = 1'b0;
  logic init_done = 1'b0;

  logic [31:0] ram     [NWORDS];
  logic [31:0] exp_mem [NWORDS];

  logic [48:0] wlog[$];
  int stb_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  wb_stream_loader #(.AWIDTH(AW), .LWIDTH(LW), .TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .start_i   (start_i),
    .base_adr_i(base_adr_i),
    .len_i     (len_i),
    .s_dat_i   (s_dat_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (rdat),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_ack_i  (ack),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  // Slave RAM: registered ack, never acks two cycles in a row.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack <= 1'b0;
    else        ack <= wb_stb_o && wb_cyc_o && !ack && ack_en;
  end

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= 32'(i) * 32'h9E37_79B1;
      init_done <= 1'b1;
    end else if (wb_stb_o && wb_cyc_o && !ack && ack_en) begin
      logic [31:0] w;
      w = ram[wb_adr_o[AW-1:2]];
      rdat <= w ^ (corrupt ? 32'h0100_0000 : 32'h0);
      if (wb_we_o) begin
        for (int l = 0; l < 4; l++)
          if (wb_sel_o[l]) w[8*l +: 8] = wb_dat_o[8*l +: 8];
        ram[wb_adr_o[AW-1:2]] <= w;
      end
    end
  end

  always @(negedge clk) begin
    if (wb_stb_o && ack && wb_we_o) wlog.push_back({wb_adr_o, wb_dat_o, wb_sel_o});
    if (wb_stb_o) stb_cnt++;
    if (done_o) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ram_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < NWORDS; i++) if (ram[i] !== exp_mem[i]) bad++;
    check_eq(tag, bad, 0);
  endtask

  // One complete load. seq=1 streams 1,2,3..; poke re-pulses start mid-load.
  task automatic run_load(input logic [AW-1:0] base, input int len, input int gap,
                          input bit seq, input bit poke, input bit chk_bus,
                          output int consumed, output int cycles);
    byte unsigned  data[$];
    logic [AW-1:0] wbase, a;
    logic [31:0]   w;
    logic [3:0]    s;
    int idx, nw, ln;
    bit acc, poked;
    for (int k = 0; k < len; k++) data.push_back(seq ? 8'(k + 1) : 8'($urandom));
    wbase = {base[AW-1:2], 2'b00};
    wlog.delete();
    stb_cnt = 0;
    @(posedge clk); #1;
    start_i = 1'b1; base_adr_i = base; len_i = LW'(len);
    @(posedge clk); #1;
    start_i = 1'b0; base_adr_i = AW'($urandom); len_i = LW'($urandom);
    idx = 0; cycles = 0; poked = 0;
    while (!done_o && cycles < 4000) begin
      start_i = 1'b0;
      if (poke && !poked && idx == 1) begin start_i = 1'b1; poked = 1; end
      s_valid_i = (idx < len) && ($urandom_range(99) >= gap);
      s_dat_i   = s_valid_i ? data[idx] : 8'($urandom);
      acc = s_valid_i && s_ready_o;
      @(posedge clk); #1;
      if (acc) idx++;
      cycles++;
    end
    start_i = 1'b0; s_valid_i = 1'b0;
    check_eq("done_seen", done_o, 1);
    check_eq("busy_at_done", busy_o, 0);
    consumed = idx;
    if (chk_bus) begin
      check_eq("bytes_consumed", idx, len);
      check_eq("err_clean", err_o, 0);
      nw = (len + 3) / 4;
      check_eq("write_count", wlog.size(), nw);
      for (int j = 0; j < nw; j++) begin
        w = '0; s = '0;
        for (int b = 0; b < 4; b++)
          if (4*j + b < len) begin
            w[8*(3-b) +: 8] = data[4*j + b];
            s[3-b] = 1'b1;
          end
        if (j < wlog.size()) check_eq("write_beat", wlog[j], {wbase + AW'(4*j), w, s});
      end
      for (int k = 0; k < len; k++) begin
        a  = wbase + AW'(k);
        ln = 3 - int'(a[1:0]);
        exp_mem[a[AW-1:2]][8*ln +: 8] = data[k];
      end
      ram_compare("ram_image");
    end
    @(posedge clk); #1;
    check_eq("done_pulse_width", done_o, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int consumed, cycles, n;
    for (int i = 0; i < NWORDS; i++) exp_mem[i] = 32'(i) * 32'h9E37_79B1;

    #1;
    check_eq("rst_stb", wb_stb_o, 0);
    check_eq("rst_cyc", wb_cyc_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_err", err_o, 0);
    check_eq("rst_ready", s_ready_o, 0);
    check_eq("rst_adr", wb_adr_o, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_load(13'h100, 8, 0, 1, 0, 1, consumed, cycles);
    check_eq("t1_word0", wlog[0], {13'h100, 32'h0102_0304, 4'hF});
    check_eq("t1_word1", wlog[1], {13'h104, 32'h0506_0708, 4'hF});

    run_load(13'h200, 5, 0, 1, 0, 1, consumed, cycles);
    check_eq("t2_word1", wlog[1], {13'h204, 32'h0500_0000, 4'h8});

    run_load(13'h300, 0, 0, 0, 0, 1, consumed, cycles);
    check_eq("len0_latency", cycles, 0);
    check_eq("len0_no_stb", stb_cnt, 0);

    run_load(13'h1FFC, 8, 40, 0, 0, 1, consumed, cycles);
    check_eq("wrap_adr0", wlog[0][48:36], 13'h1FFC);
    check_eq("wrap_adr1", wlog[1][48:36], 13'h0000);

    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(19, 1);
      run_load(AW'($urandom), n, $urandom_range(60, 0), 0, ($urandom_range(1, 0) == 1), 1,
               consumed, cycles);
    end

    ack_en = 1'b0;
    run_load(13'h040, 8, 0, 0, 0, 0, consumed, cycles);
    check_eq("to_stb_cycles", stb_cnt, TO);
    check_eq("to_err", err_o, 1);
    check_eq("to_stb_low", wb_stb_o, 0);
    check_eq("to_bytes_left", consumed, 4);
    ack_en = 1'b1;
    ram_compare("to_ram_untouched");
    run_load(13'h080, 6, 20, 0, 0, 1, consumed, cycles);

    ack_en = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; base_adr_i = 13'h300; len_i = 16'd4;
    @(posedge clk); #1;
    start_i = 1'b0; s_valid_i = 1'b1;
    n = 0;
    while (!wb_stb_o && n < 50) begin @(posedge clk); #1; n++; end
    s_valid_i = 1'b0;
    check_eq("rst_mid_reached_write", wb_stb_o, 1);
    repeat (3) @(posedge clk);
    #1 done_cnt = 0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_stb", wb_stb_o, 0);
    check_eq("rst_mid_cyc", wb_cyc_o, 0);
    check_eq("rst_mid_busy", busy_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mid_no_done", done_cnt, 0);
    ack_en = 1'b1;
    ram_compare("rst_mid_ram");

`ifdef WB_STREAM_LOADER_VERIFY_EN
    corrupt = 1'b1;
    run_load(13'h400, 4, 0, 0, 0, 0, consumed, cycles);
    check_eq("verify_err", err_o, 1);
    corrupt = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
